// File: rtl/pixel_pair_proc.sv
// pixel_pair_proc: streaming point operation on two RGB pixels per clock.
//   Sits downstream of the sensor model. It takes VSYNC/HSYNC strobes and an
//   even/odd pixel pair per cycle. It applies an operation latched at frame
//   start (bypass, saturating brightness, invert, grayscale threshold). It
//   emits the pair two cycles later with line-end, frame-done and frame-error
//   flags.
// Ports:
//   HCLK, HRESETn            clock (rising), async active-low reset
//   VSYNC, HSYNC             frame-start strobe, pixel-pair valid
//   DATA_{R,G,B}{0,1}        even (0) / odd (1) column pixel in
//   cfg_mode/value/sub       operation select, offset/threshold, subtract flag
//   OUT_{R,G,B}{0,1}         processed pixels (hold when o_valid=0)
//   o_valid, o_line_end      output pair valid, last pair of a line
//   o_frame_done             pulse one cycle after the last pair of a frame
//   o_frame_err              sticky: frame restarted before completion
//   o_busy                   frame in progress (ACTIVE or FLUSH)

// One pixel lane: stage 1 precomputes gray and the brightness sums, stage 2
// selects the result for the mode carried alongside the pair.
module pixel_pair_proc_lane (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            i_ld1,       // pair accepted this cycle
  input  logic            i_ld2,       // stage 1 holds a valid pair
  input  logic [2:0][7:0] i_pix,       // [2]=R [1]=G [0]=B
  input  logic [7:0]      i_value,     // frame config at acceptance
  input  logic            i_sub,
  input  logic [1:0]      i_s1_mode,   // config travelling with stage 1
  input  logic [7:0]      i_s1_value,
  input  logic            i_s1_sub,
  output logic [2:0][7:0] o_pix
);
  logic [2:0][7:0] r_pix;
  logic [2:0][8:0] r_bri;
  logic [7:0]      r_gray;
  logic [2:0][8:0] w_bri;
  logic [9:0]      w_sum;
  logic [7:0]      w_gray;
  logic [2:0][7:0] w_res;

  // Bit 8 of the 9-bit result flags overflow (add) or borrow (subtract).
  always_comb begin
    for (int c = 0; c < 3; c++)
      w_bri[c] = i_sub ? ({1'b0, i_pix[c]} - {1'b0, i_value})
                       : ({1'b0, i_pix[c]} + {1'b0, i_value});
  end

  assign w_sum  = {2'b00, i_pix[2]} + {1'b0, i_pix[1], 1'b0} + {2'b00, i_pix[0]};
  assign w_gray = 8'(w_sum >> 2);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pix  <= '0;
      r_bri  <= '0;
      r_gray <= '0;
    end else if (i_ld1) begin
      r_pix  <= i_pix;
      r_bri  <= w_bri;
      r_gray <= w_gray;
    end
  end

  always_comb begin
    w_res = r_pix;
    case (i_s1_mode)
      2'd1: begin
        for (int c = 0; c < 3; c++)
          w_res[c] = r_bri[c][8] ? (i_s1_sub ? 8'h00 : 8'hFF) : r_bri[c][7:0];
      end
      2'd2:    w_res = ~r_pix;
      2'd3:    w_res = (r_gray > i_s1_value) ? '1 : '0;  // equal maps to 0
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)   o_pix <= '0;
    else if (i_ld2) o_pix <= w_res;
  end
endmodule

module pixel_pair_proc #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       VSYNC,
  input  logic       HSYNC,
  input  logic [7:0] DATA_R0,
  input  logic [7:0] DATA_G0,
  input  logic [7:0] DATA_B0,
  input  logic [7:0] DATA_R1,
  input  logic [7:0] DATA_G1,
  input  logic [7:0] DATA_B1,
  input  logic [1:0] cfg_mode,
  input  logic [7:0] cfg_value,
  input  logic       cfg_sub,
  output logic [7:0] OUT_R0,
  output logic [7:0] OUT_G0,
  output logic [7:0] OUT_B0,
  output logic [7:0] OUT_R1,
  output logic [7:0] OUT_G1,
  output logic [7:0] OUT_B1,
  output logic       o_valid,
  output logic       o_line_end,
  output logic       o_frame_done,
  output logic       o_frame_err,
  output logic       o_busy
);
  localparam int NUM_PIX = 2;
  localparam int STAGES  = 2;
  localparam int COL_W   = $clog2(WIDTH / 2);
  localparam int ROW_W   = $clog2(HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH / 2 - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH, S_DONE} state_t;

  state_t                           r_state, w_next;
  logic [COL_W-1:0]                 r_col;
  logic [ROW_W-1:0]                 r_row;
  logic                             r_flush_cnt;
  logic [1:0]                       r_cfg_mode;
  logic [7:0]                       r_cfg_value;
  logic                             r_cfg_sub;
  logic [1:0]                       r_s1_mode;
  logic [7:0]                       r_s1_value;
  logic                             r_s1_sub;
  logic [STAGES:1]                  r_vld_pipe;
  logic [STAGES:1]                  r_le_pipe;
  logic                             w_accept;
  logic                             w_col_last;
  logic                             w_last;
  logic [NUM_PIX-1:0][2:0][7:0]     w_pix_in;
  logic [NUM_PIX-1:0][2:0][7:0]     w_pix_out;

  // A VSYNC cycle never carries a pair, even in ACTIVE.
  assign w_accept   = (r_state == S_ACTIVE) && HSYNC && !VSYNC;
  assign w_col_last = (r_col == COL_LAST);
  assign w_last     = w_accept && w_col_last && (r_row == ROW_LAST);

  // FSM: state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // FSM: next state (VSYNC restarts from any state)
  always_comb begin
    w_next = r_state;
    if (VSYNC) w_next = S_ACTIVE;
    else begin
      case (r_state)
        S_ACTIVE: if (w_last) w_next = S_FLUSH;
        S_FLUSH:  if (r_flush_cnt) w_next = S_DONE;
        S_DONE:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    o_busy       = (r_state == S_ACTIVE) || (r_state == S_FLUSH);
    o_frame_done = (r_state == S_DONE);
  end

  // Counters, frame config and the sticky error flag
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_col       <= '0;
      r_row       <= '0;
      r_flush_cnt <= 1'b0;
      r_cfg_mode  <= '0;
      r_cfg_value <= '0;
      r_cfg_sub   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      r_flush_cnt <= (r_state == S_FLUSH) ? ~r_flush_cnt : 1'b0;
      if (VSYNC) begin
        r_col       <= '0;
        r_row       <= '0;
        r_cfg_mode  <= cfg_mode;
        r_cfg_value <= cfg_value;
        r_cfg_sub   <= cfg_sub;
        o_frame_err <= (r_state == S_ACTIVE) || (r_state == S_FLUSH);
      end else if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  // Valid/line-end shift registers; stage-1 config rides with its pair so
  // in-flight pairs keep their frame's operation across a restart.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_vld_pipe <= '0;
      r_le_pipe  <= '0;
      r_s1_mode  <= '0;
      r_s1_value <= '0;
      r_s1_sub   <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_accept};
      r_le_pipe  <= {r_le_pipe[STAGES-1:1], w_accept && w_col_last};
      if (w_accept) begin
        r_s1_mode  <= r_cfg_mode;
        r_s1_value <= r_cfg_value;
        r_s1_sub   <= r_cfg_sub;
      end
    end
  end

  assign w_pix_in[0] = {DATA_R0, DATA_G0, DATA_B0};
  assign w_pix_in[1] = {DATA_R1, DATA_G1, DATA_B1};

  for (genvar p = 0; p < NUM_PIX; p++) begin : g_lane
    pixel_pair_proc_lane u_lane (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .i_ld1      (w_accept),
      .i_ld2      (r_vld_pipe[1]),
      .i_pix      (w_pix_in[p]),
      .i_value    (r_cfg_value),
      .i_sub      (r_cfg_sub),
      .i_s1_mode  (r_s1_mode),
      .i_s1_value (r_s1_value),
      .i_s1_sub   (r_s1_sub),
      .o_pix      (w_pix_out[p])
    );
  end

  assign {OUT_R0, OUT_G0, OUT_B0} = w_pix_out[0];
  assign {OUT_R1, OUT_G1, OUT_B1} = w_pix_out[1];
  assign o_valid    = r_vld_pipe[STAGES];
  assign o_line_end = r_le_pipe[STAGES];
endmodule

// File: tb/tb_pixel_pair_proc.sv
module tb_pixel_pair_proc;
  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       VSYNC, HSYNC;
  logic [7:0] DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_value;
  logic       cfg_sub;
  logic [7:0] OUT_R0, OUT_G0, OUT_B0, OUT_R1, OUT_G1, OUT_B1;
  logic       o_valid, o_line_end, o_frame_done, o_frame_err, o_busy;

  int n_chk = 0;
  int n_err = 0;

  // Expectation for the pair driven on the previous step
  logic        p_acc = 1'b0;
  logic        p_le  = 1'b0;
  logic [47:0] p_exp = '0;

  pixel_pair_proc #(.WIDTH(8), .HEIGHT(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .cfg_mode(cfg_mode), .cfg_value(cfg_value), .cfg_sub(cfg_sub),
    .OUT_R0(OUT_R0), .OUT_G0(OUT_G0), .OUT_B0(OUT_B0),
    .OUT_R1(OUT_R1), .OUT_G1(OUT_G1), .OUT_B1(OUT_B1),
    .o_valid(o_valid), .o_line_end(o_line_end), .o_frame_done(o_frame_done),
    .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] ramp(input int k);
    logic [47:0] r;
    for (int j = 0; j < 6; j++) r[47-8*j -: 8] = 8'(k * 16 + j);
    return r;
  endfunction

  // One clock: drive inputs, clock, then check the pair driven one step ago.
  task automatic step(input logic vs, input logic hs, input logic acc,
                      input logic le, input logic [47:0] d, input logic [47:0] e);
    VSYNC = vs; HSYNC = hs;
    {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1} = d;
    @(posedge HCLK); #1;
    chk("valid", o_valid, p_acc);
    if (p_acc) begin
      chk("pixels", {OUT_R0, OUT_G0, OUT_B0, OUT_R1, OUT_G1, OUT_B1}, p_exp);
      chk("line_end", o_line_end, p_le);
    end
    chk("done_vs_valid", o_frame_done && o_valid, 1'b0);
    p_acc = acc; p_le = le; p_exp = e;
  endtask

  // n accepted pairs; gap_mask marks HSYNC=0 steps; cst selects constant data.
  task automatic frame(input int n, input logic [15:0] gap_mask, input logic cst,
                       input logic [47:0] cd, input logic [47:0] ce, input logic inv,
                       input int tog_step, input logic [1:0] tog_mode);
    int k;
    int s;
    logic [47:0] d;
    logic [47:0] e;
    k = 0; s = 0;
    while (k < n) begin
      if (s == tog_step) cfg_mode = tog_mode;
      if (gap_mask[s]) step(1'b0, 1'b0, 1'b0, 1'b0, ramp(15), '0);
      else begin
        d = cst ? cd : ramp(k);
        e = cst ? ce : (inv ? ~d : d);
        step(1'b0, 1'b1, 1'b1, (k % 4) == 3, d, e);
        k++;
      end
      s++;
    end
  endtask

  task automatic drain(input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk({tag, "_done_early"}, o_frame_done, 1'b0);
    chk({tag, "_busy_flush"}, o_busy, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk({tag, "_done"}, o_frame_done, 1'b1);
    chk({tag, "_busy_done"}, o_busy, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk({tag, "_done_pulse"}, o_frame_done, 1'b0);
  endtask

  task automatic vsync();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    HRESETn = 1'b0; VSYNC = 1'b0; HSYNC = 1'b0;
    {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1} = '0;
    cfg_mode = 2'd0; cfg_value = 8'd0; cfg_sub = 1'b0;
    #2;
    chk("reset_out", {OUT_R0, OUT_G0, OUT_B0, OUT_R1, OUT_G1, OUT_B1, o_valid,
                      o_line_end, o_frame_done, o_frame_err, o_busy}, '0);
    #10 HRESETn = 1'b1;

    // Bypass, ramp data, back-to-back
    vsync();
    chk("bypass_busy", o_busy, 1'b1);
    frame(8, 16'h0000, 1'b0, '0, '0, 1'b0, -1, 2'd0);
    drain("bypass");
    chk("bypass_err", o_frame_err, 1'b0);

    // Brightness add 100: (200,50,155) -> (255,150,255)
    cfg_mode = 2'd1; cfg_value = 8'd100; cfg_sub = 1'b0;
    vsync();
    frame(8, 16'h0000, 1'b1, 48'hC8329B_C8329B, 48'hFF96FF_FF96FF, 1'b0, -1, 2'd0);
    drain("bright_add");

    // Brightness subtract 100: -> (100,0,55)
    cfg_sub = 1'b1;
    vsync();
    frame(8, 16'h0000, 1'b1, 48'hC8329B_C8329B, 48'h640037_640037, 1'b0, -1, 2'd0);
    drain("bright_sub");

    // Threshold 127: gray 128 -> white, gray 127 -> black
    cfg_mode = 2'd3; cfg_value = 8'd127; cfg_sub = 1'b0;
    vsync();
    frame(8, 16'h0000, 1'b1, 48'h808080_7F7F80, 48'hFFFFFF_000000, 1'b0, -1, 2'd0);
    drain("thresh");

    // Invert with gaps; cfg_mode changed mid-frame must not take effect
    cfg_mode = 2'd2;
    vsync();
    frame(8, 16'h0044, 1'b0, '0, '0, 1'b1, 3, 2'd0);
    drain("gaps");

    // Early restart after 3 pairs; HSYNC with the VSYNC is ignored
    cfg_mode = 2'd0;
    vsync();
    frame(3, 16'h0000, 1'b0, '0, '0, 1'b0, -1, 2'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, ramp(9), '0);
    chk("restart_err", o_frame_err, 1'b1);
    chk("restart_busy", o_busy, 1'b1);
    frame(8, 16'h0000, 1'b0, '0, '0, 1'b0, -1, 2'd0);
    drain("restart");
    chk("err_sticky", o_frame_err, 1'b1);
    vsync();
    chk("err_cleared", o_frame_err, 1'b0);

    // Asynchronous reset mid-line, between clock edges
    frame(2, 16'h0000, 1'b0, '0, '0, 1'b0, -1, 2'd0);
    #3 HRESETn = 1'b0;
    #1;
    chk("async_reset_out", {OUT_R0, OUT_G0, OUT_B0, OUT_R1, OUT_G1, OUT_B1, o_valid,
                            o_line_end, o_frame_done, o_frame_err, o_busy}, '0);
    #2 HRESETn = 1'b1;
    p_acc = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, ramp(i), '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("post_reset_idle", o_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pixel_pair_proc.md
Name: pixel_pair_proc

Overview:
- Streaming point-operation stage placed directly downstream of the image sensor model.
- Consumes the sensor's VSYNC/HSYNC strobes and two RGB pixels per clock (pixel 0 = even column, pixel 1 = odd column).
- Applies one frame-latched operation: bypass, saturating brightness adjust, invert, or grayscale threshold.
- Emits an aligned two-pixel stream plus line-end, frame-done and frame-error indications for the writer/checker stage.

Parameters:
WIDTH, 768, pixels per line (even, >= 4)
HEIGHT, 512, lines per frame (>= 2)

Ports:
HCLK  in  1  clock, rising edge
HRESETn  in  1  asynchronous active-low reset
VSYNC  in  1  frame-start strobe from sensor
HSYNC  in  1  pixel-pair valid from sensor
DATA_R0, DATA_G0, DATA_B0  in  8 each  even-column pixel
DATA_R1, DATA_G1, DATA_B1  in  8 each  odd-column pixel
cfg_mode  in  2  0 bypass, 1 brightness, 2 invert, 3 threshold
cfg_value  in  8  brightness offset or threshold level
cfg_sub  in  1  brightness: 1 = subtract, 0 = add
OUT_R0, OUT_G0, OUT_B0, OUT_R1, OUT_G1, OUT_B1  out  8 each  processed pixels
o_valid  out  1  output pair valid
o_line_end  out  1  qualifies the last pair of a line
o_frame_done  out  1  one-cycle pulse after the last pair of a frame
o_frame_err  out  1  sticky flag: frame restarted early
o_busy  out  1  high in ACTIVE or FLUSH

Behaviour:
- Reset (async, HRESETn=0):
  - All outputs 0.
  - State IDLE; counters 0; latched config = mode 0, value 0, sub 0.
- FSM: IDLE, ACTIVE, FLUSH, DONE.
- IDLE:
  - HSYNC is ignored.
  - VSYNC=1 latches cfg_mode/cfg_value/cfg_sub, clears col/row counters, goes to ACTIVE.
- ACTIVE:
  - Each cycle with HSYNC=1 (and VSYNC=0) accepts one pair.
  - col counts 0..WIDTH/2-1 and wraps to 0 while row increments.
  - The pair with col=WIDTH/2-1 is tagged line_end.
  - The pair with col=WIDTH/2-1 and row=HEIGHT-1 is tagged last; next state is FLUSH.
  - HSYNC=0 cycles are gaps; counters hold.
- VSYNC=1 in ACTIVE or FLUSH (early restart):
  - Set o_frame_err.
  - Relatch config, clear counters, state ACTIVE.
  - Pairs already in the pipeline still drain with their original config.
  - HSYNC in the same cycle as VSYNC is ignored.
- FLUSH: 2 cycles (pipeline drain), then DONE.
- DONE:
  - o_frame_done=1 for exactly this cycle, then IDLE.
  - A VSYNC in DONE is accepted as an IDLE VSYNC.
- o_frame_err clears only on reset or on a VSYNC accepted from IDLE/DONE.
- Pipeline: 2 register stages, latency exactly 2 cycles.
  - Pair accepted at cycle N appears on OUT_* with o_valid=1 at cycle N+2.
  - o_line_end is delayed identically.
  - OUT_* hold their last values when o_valid=0.
- Stage 1: per pixel, gray = (R + 2G + B) >> 2, using a 10-bit sum; 9-bit sum/difference for brightness.
- Stage 2, per pixel and per channel:
  - mode 0: output = input.
  - mode 1, add: min(c + value, 255).
  - mode 1, subtract: max(c - value, 0).
  - mode 2: 255 - c.
  - mode 3: all three channels = 255 if gray > value, else 0 (equal maps to 0).
- Pixel 0 and pixel 1 are processed independently and identically.
- Config inputs changing mid-frame have no effect until the next accepted VSYNC.
- o_frame_done and o_valid of the last pair never coincide; o_frame_done follows 1 cycle after the last o_valid.

Test Plan:
- WIDTH=8, HEIGHT=2, mode 0, VSYNC then 8 back-to-back HSYNC pairs of ramp data:
  - Outputs equal inputs 2 cycles later.
  - o_line_end on pairs 4 and 8.
  - o_frame_done 1 cycle after the 8th o_valid; o_frame_err=0.
- Mode 1, add, value 100; pixels R=200, G=50, B=155 -> 255, 150, 255.
- Mode 1, subtract, value 100; same pixels -> 100, 0, 55.
- Mode 3, value 127:
  - (R,G,B)=(128,128,128) gives gray 128 -> 255, 255, 255.
  - (127,127,128) gives gray 127 -> 0, 0, 0.
- HSYNC gaps inserted mid-line with cfg_mode toggled mid-frame:
  - Counts unaffected and o_line_end positions unchanged.
  - Frame processed wholly with the mode latched at VSYNC.
- VSYNC after 3 pairs:
  - o_frame_err=1 and in-flight pairs still emitted.
  - New frame of 8 pairs completes with o_frame_done.
  - Next clean VSYNC clears o_frame_err.
- HRESETn asserted mid-line, asynchronously between clock edges:
  - All outputs 0 immediately.
  - After release, HSYNC without VSYNC produces no o_valid.
